// File: rtl/video_pkg.sv
// ============================================================================
// video_pkg : shared pixel type, pattern codes and colour constants
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package video_pkg;

  localparam int PIX_W = 24;
  typedef logic [PIX_W-1:0] pixel_t;

  localparam logic [2:0] PAT_BARS  = 3'd0;
  localparam logic [2:0] PAT_GRID  = 3'd1;
  localparam logic [2:0] PAT_GRAD  = 3'd2;
  localparam logic [2:0] PAT_BOX   = 3'd3;
  localparam logic [2:0] PAT_SOLID = 3'd4;

  localparam pixel_t C_WHITE     = 24'hFFFFFF;
  localparam pixel_t C_YELLOW    = 24'hFFFF00;
  localparam pixel_t C_CYAN      = 24'h00FFFF;
  localparam pixel_t C_GREEN     = 24'h00FF00;
  localparam pixel_t C_MAGENTA   = 24'hFF00FF;
  localparam pixel_t C_RED       = 24'hFF0000;
  localparam pixel_t C_BLUE      = 24'h0000FF;
  localparam pixel_t C_BLACK     = 24'h000000;
  localparam pixel_t C_DARK_BLUE = 24'h000040;

  function automatic pixel_t bar_colour(input logic [2:0] idx);
    pixel_t c;
    case (idx)
      3'd0:    c = C_WHITE;
      3'd1:    c = C_YELLOW;
      3'd2:    c = C_CYAN;
      3'd3:    c = C_GREEN;
      3'd4:    c = C_MAGENTA;
      3'd5:    c = C_RED;
      3'd6:    c = C_BLUE;
      default: c = C_BLACK;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/video_raster_cnt.sv
// ============================================================================
// video_raster_cnt : x/y raster position and colour-bar index tracking
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module video_raster_cnt #(
  parameter int IMAGE_WIDTH = 11
) (
  input  logic                   pix_clk,
  input  logic                   rst_n,
  input  logic [IMAGE_WIDTH-1:0] disp_w,
  input  logic [IMAGE_WIDTH-1:0] disp_h,
  input  logic                   frame_end,
  input  logic                   pixel_req,
  output logic [IMAGE_WIDTH-1:0] x,
  output logic [IMAGE_WIDTH-1:0] y,
  output logic [2:0]             bar_idx
);

  localparam logic [IMAGE_WIDTH-1:0] C_ONE = {{(IMAGE_WIDTH-1){1'b0}}, 1'b1};

  logic [IMAGE_WIDTH-1:0] r_x, r_y, r_bar_cnt;
  logic [2:0]             r_bar_idx;
  logic [IMAGE_WIDTH-1:0] w_bar_w, w_x_last, w_y_last;

  // A zero dimension wraps to all-ones here, giving a full 2^IMAGE_WIDTH span
  assign w_bar_w  = disp_w >> 3;
  assign w_x_last = disp_w - C_ONE;
  assign w_y_last = disp_h - C_ONE;

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x       <= '0;
      r_y       <= '0;
      r_bar_cnt <= '0;
      r_bar_idx <= 3'd0;
    end else if (frame_end) begin
      r_x       <= '0;
      r_y       <= '0;
      r_bar_cnt <= '0;
      r_bar_idx <= 3'd0;
    end else if (pixel_req) begin
      if (r_x == w_x_last) begin
        r_x       <= '0;
        r_bar_cnt <= '0;
        r_bar_idx <= 3'd0;
        r_y       <= (r_y == w_y_last) ? '0 : r_y + C_ONE;
      end else begin
        r_x <= r_x + C_ONE;
        // Bar 7 absorbs any remainder pixels at the right edge
        if ((w_bar_w != '0) && (r_bar_cnt == w_bar_w - C_ONE)) begin
          r_bar_cnt <= '0;
          if (r_bar_idx != 3'd7)
            r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
          r_bar_cnt <= r_bar_cnt + C_ONE;
        end
      end
    end
  end

  assign x       = r_x;
  assign y       = r_y;
  assign bar_idx = r_bar_idx;

endmodule

`default_nettype wire

// File: rtl/video_pattern_gen.sv
// ============================================================================
// video_pattern_gen : test-pattern pixel source for the HDMI output path
// Option macro      : VIDEO_PATTERN_BORDER_EN (white 1-pixel frame border)
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none

module video_pattern_gen
  import video_pkg::*;
#(
  parameter int IMAGE_WIDTH     = 11,
  parameter int HDMI_DATA_WIDTH = 24,
  parameter int BOX_SIZE        = 64
) (
  input  logic                       pix_clk,
  input  logic                       rst_n,
  input  logic [IMAGE_WIDTH-1:0]     disp_w,
  input  logic [IMAGE_WIDTH-1:0]     disp_h,
  input  logic                       frame_end,
  input  logic [2:0]                 pattern_sel,
  input  logic                       pixel_req,
  output logic [HDMI_DATA_WIDTH-1:0] pixel_data,
  output logic                       pixel_valid
);

  localparam logic [IMAGE_WIDTH-1:0] C_BOX = BOX_SIZE[IMAGE_WIDTH-1:0];

  logic [IMAGE_WIDTH-1:0] w_x, w_y, w_box_x, w_box_y, w_dx, w_dy;
  logic [2:0]             w_bar_idx;
  logic [7:0]             r_frame_cnt;
  logic [2:0]             r_active_sel;
  logic                   w_in_box;
  pixel_t                 w_pattern, w_pixel;

  video_raster_cnt #(
    .IMAGE_WIDTH (IMAGE_WIDTH)
  ) u_raster (
    .pix_clk   (pix_clk),
    .rst_n     (rst_n),
    .disp_w    (disp_w),
    .disp_h    (disp_h),
    .frame_end (frame_end),
    .pixel_req (pixel_req),
    .x         (w_x),
    .y         (w_y),
    .bar_idx   (w_bar_idx)
  );

  // Box drifts 2 px right and 1 px down per frame; unsigned wrap handles the edges
  assign w_box_x  = {{(IMAGE_WIDTH-9){1'b0}}, r_frame_cnt, 1'b0};
  assign w_box_y  = {{(IMAGE_WIDTH-8){1'b0}}, r_frame_cnt};
  assign w_dx     = w_x - w_box_x;
  assign w_dy     = w_y - w_box_y;
  assign w_in_box = (w_dx < C_BOX) && (w_dy < C_BOX);

  always_comb begin
    w_pattern = C_BLACK;
    case (r_active_sel)
      PAT_BARS:  w_pattern = bar_colour(w_bar_idx);
      PAT_GRID:  w_pattern = ((w_x[4:0] == 5'd0) || (w_y[4:0] == 5'd0)) ? C_WHITE : C_BLACK;
      PAT_GRAD:  w_pattern = {3{w_x[7:0]}};
      PAT_BOX:   w_pattern = w_in_box ? C_WHITE : C_DARK_BLUE;
      PAT_SOLID: w_pattern = C_RED;
      default:   w_pattern = C_BLACK;
    endcase
  end

`ifdef VIDEO_PATTERN_BORDER_EN
  logic w_border;
  assign w_border = (w_x == '0) || (w_x == disp_w - 1'b1) ||
                    (w_y == '0) || (w_y == disp_h - 1'b1);
  assign w_pixel  = w_border ? C_WHITE : w_pattern;
`else
  assign w_pixel  = w_pattern;
`endif

  // A request coinciding with frame_end is answered with the old position and selection
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_data   <= '0;
      pixel_valid  <= 1'b0;
      r_frame_cnt  <= 8'd0;
      r_active_sel <= 3'd0;
    end else begin
      pixel_valid <= pixel_req;
      if (pixel_req)
        pixel_data <= w_pixel;
      if (frame_end) begin
        r_frame_cnt  <= r_frame_cnt + 8'd1;
        r_active_sel <= pattern_sel;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_video_pattern_gen.sv
// ============================================================================
// tb_video_pattern_gen : randomized self-checking bench for video_pattern_gen
// Rev 1.0              : initial release
// ============================================================================
`default_nettype none

module tb_video_pattern_gen;

  logic        pix_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] disp_w = 11'd16;
  logic [10:0] disp_h = 11'd4;
  logic        frame_end = 1'b0;
  logic [2:0]  pattern_sel = 3'd0;
  logic        pixel_req = 1'b0;
  logic [23:0] pixel_data;
  logic        pixel_valid;

  video_pattern_gen #(
    .IMAGE_WIDTH     (11),
    .HDMI_DATA_WIDTH (24),
    .BOX_SIZE        (64)
  ) dut (
    .pix_clk     (pix_clk),
    .rst_n       (rst_n),
    .disp_w      (disp_w),
    .disp_h      (disp_h),
    .frame_end   (frame_end),
    .pattern_sel (pattern_sel),
    .pixel_req   (pixel_req),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid)
  );

  always #5 pix_clk = ~pix_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference raster state
  int          mx = 0, my = 0, mfc = 0, msel = 0;
  logic [23:0] last_data = 24'h0;
  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int dim(input logic [10:0] d);
    return (d == 11'd0) ? 2048 : int'(d);
  endfunction

  function automatic logic [23:0] model_pix(input int x, input int y);
    int bw, idx, dx, dy;
    logic [7:0] g;
    logic [23:0] p;
    bw = int'(disp_w) / 8;
    case (msel)
      0: begin
        idx = (bw == 0) ? 0 : x / bw;
        if (idx > 7) idx = 7;
        p = bar_tab[idx];
      end
      1: p = ((x % 32 == 0) || (y % 32 == 0)) ? 24'hFFFFFF : 24'h000000;
      2: begin
        g = 8'(x % 256);
        p = {g, g, g};
      end
      3: begin
        dx = ((x - 2 * mfc) % 2048 + 2048) % 2048;
        dy = ((y - mfc) % 2048 + 2048) % 2048;
        p = (dx < 64 && dy < 64) ? 24'hFFFFFF : 24'h000040;
      end
      4: p = 24'hFF0000;
      default: p = 24'h000000;
    endcase
`ifdef VIDEO_PATTERN_BORDER_EN
    if (x == 0 || x == dim(disp_w) - 1 || y == 0 || y == dim(disp_h) - 1)
      p = 24'hFFFFFF;
`endif
    return p;
  endfunction

  task automatic step(input logic req, input logic fe);
    logic [23:0] e_data;
    pixel_req = req;
    frame_end = fe;
    e_data = req ? model_pix(mx, my) : last_data;
    @(posedge pix_clk);
    #1;
    check($sformatf("valid(%0d,%0d)", mx, my), {31'b0, pixel_valid}, {31'b0, req});
    check($sformatf("%s(%0d,%0d) sel%0d", req ? "pix" : "hold", mx, my, msel),
          {8'h0, pixel_data}, {8'h0, e_data});
    last_data = e_data;
    if (fe) begin
      mx = 0; my = 0; mfc = (mfc + 1) % 256; msel = int'(pattern_sel);
    end else if (req) begin
      mx++;
      if (mx == dim(disp_w)) begin
        mx = 0; my++;
        if (my == dim(disp_h)) my = 0;
      end
    end
    pixel_req = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", {31'b0, pixel_valid}, 32'd0);
    check("rst_data", {8'h0, pixel_data}, 32'd0);
    mx = 0; my = 0; mfc = 0; msel = 0; last_data = 24'h0;
    @(posedge pix_clk);
    #1 rst_n = 1'b1;
  endtask

  // Frame boundary first, then new geometry, so no line is split across two geometries
  task automatic new_frame(input int w, input int h, input int sel);
    pattern_sel = 3'(sel);
    step(1'b0, 1'b1);
    disp_w = 11'(w);
    disp_h = 11'(h);
  endtask

  initial begin
    repeat (3) @(posedge pix_clk);
    #1;
    check("reset_valid", {31'b0, pixel_valid}, 32'd0);
    check("reset_data", {8'h0, pixel_data}, 32'd0);
    rst_n = 1'b1;

    // Colour bars, bar width 2
    new_frame(16, 4, 0);
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0);

    // Gapped gradient across the 8-bit wrap
    new_frame(300, 3, 2);
    for (int i = 0; i < 1800; i++) step(i % 3 == 0, 1'b0);

    // Selection change mid-frame waits for frame_end
    new_frame(16, 4, 0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    pattern_sel = 3'd4;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);

    // frame_end together with a request at (7,2)
    new_frame(16, 4, 2);
    for (int i = 0; i < 39; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);

    // Moving box at frame_cnt = 5
    do_reset();
    new_frame(80, 72, 3);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 80 * 72; i++) step(1'b1, 1'b0);

    // Bar 7 saturation, then reset mid-line
    new_frame(20, 3, 0);
    for (int i = 0; i < 60; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0);

    // Random traffic with random geometry and selection
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        new_frame(int'($urandom_range(1, 40)), int'($urandom_range(1, 6)),
                  int'($urandom_range(0, 7)));
      end else begin
        if ($urandom_range(0, 49) == 0) pattern_sel = 3'($urandom_range(0, 7));
        step($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
